// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and parity mode constants.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

endpackage

// File: rtl/uart_tx.sv
// UART transmitter with a one-entry holding register; each bit lasts exactly
// one baud_tick interval and frames chain back-to-back when a byte is waiting.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 baud_tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 txd,
  output logic                 busy
);

  localparam logic [2:0] DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic       ODD_INV   = (PARITY == PAR_ODD);

  uart_state_t          state, state_nxt;
  logic                 txd_nxt;
  logic [2:0]           bit_cnt, cnt_nxt;
  logic [DATA_BITS-1:0] shift, shift_nxt;
  logic [DATA_BITS-1:0] hold_data;
  logic                 hold_full;
  logic                 par_bit;
  logic                 load;
  logic                 accept;

  assign accept   = tx_valid && !hold_full;
  assign tx_ready = !hold_full;
  assign busy     = (state != ST_IDLE);

  always_comb begin
    state_nxt = state;
    txd_nxt   = txd;
    cnt_nxt   = bit_cnt;
    shift_nxt = shift;
    load      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (baud_tick && hold_full) begin
          load      = 1'b1;
          txd_nxt   = 1'b0;
          state_nxt = ST_START;
        end
      end
      ST_START: begin
        if (baud_tick) begin
          txd_nxt   = shift[0];
          shift_nxt = shift >> 1;
          cnt_nxt   = 3'd0;
          state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (baud_tick) begin
          if (bit_cnt == DATA_LAST) begin
            cnt_nxt = 3'd0;
            if (PARITY != PAR_NONE) begin
              txd_nxt   = par_bit;
              state_nxt = ST_PARITY;
            end else begin
              txd_nxt   = 1'b1;
              state_nxt = ST_STOP;
            end
          end else begin
            txd_nxt   = shift[0];
            shift_nxt = shift >> 1;
            cnt_nxt   = bit_cnt + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        if (baud_tick) begin
          txd_nxt   = 1'b1;
          cnt_nxt   = 3'd0;
          state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        if (baud_tick) begin
          if (bit_cnt == STOP_LAST) begin
            cnt_nxt = 3'd0;
            // A waiting byte starts on the final stop tick, leaving no idle gap.
            if (hold_full) begin
              load      = 1'b1;
              txd_nxt   = 1'b0;
              state_nxt = ST_START;
            end else begin
              txd_nxt   = 1'b1;
              state_nxt = ST_IDLE;
            end
          end else begin
            cnt_nxt = bit_cnt + 3'd1;
          end
        end
      end
      default: begin
        txd_nxt   = 1'b1;
        cnt_nxt   = 3'd0;
        state_nxt = ST_IDLE;
      end
    endcase
    if (load) shift_nxt = hold_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      txd       <= 1'b1;
      bit_cnt   <= 3'd0;
      hold_full <= 1'b0;
    end else begin
      state   <= state_nxt;
      txd     <= txd_nxt;
      bit_cnt <= cnt_nxt;
      if (load)        hold_full <= 1'b0;
      else if (accept) hold_full <= 1'b1;
    end
  end

  // Data path carries no reset; it is only consumed after a load.
  always_ff @(posedge clk) begin
    shift <= shift_nxt;
    if (accept) hold_data <= tx_data;
    if (load)   par_bit   <= (^hold_data) ^ ODD_INV;
  end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: four parameter sets share clock, reset and tick.
module tb_uart_tx;

  localparam int NCH = 4;

  logic clk = 1'b0;
  logic reset_n;
  logic baud_tick;
  bit   tick_mode;
  int   gap_max;
  int   checks = 0;
  int   errors = 0;

  byte unsigned req_q[NCH][$];
  bit           ch_idle[NCH];
  logic         busy_v[NCH];
  logic         ready_v[NCH];
  logic         txd_v[NCH];

  always #5 clk = ~clk;

  function automatic void check(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
    end
  endfunction

  // Tick every 4 clocks, or in pairs of consecutive cycles when tick_mode is set.
  initial begin
    int ph;
    ph = 0;
    baud_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      ph = (ph + 1) % 4;
      baud_tick = tick_mode ? (ph < 2) : (ph == 0);
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    localparam int D  = (g == 3) ? 5 : 8;
    localparam int P  = (g == 0) ? 0 : ((g == 2) ? 2 : 1);
    localparam int S  = (g >= 2) ? 2 : 1;
    localparam int FL = 1 + D + ((P != 0) ? 1 : 0) + S;

    logic [D-1:0] tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic         txd;
    logic         busy;
    byte unsigned exp_q[$];
    bit           drv_active;
    int           nbits;
    logic [15:0]  got;

    uart_tx #(.DATA_BITS(D), .PARITY(P), .STOP_BITS(S)) u_dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .baud_tick(baud_tick),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .txd      (txd),
      .busy     (busy)
    );

    assign busy_v[g]  = busy;
    assign ready_v[g] = tx_ready;
    assign txd_v[g]   = txd;

    // Line image of a frame: bit i is the level during the i-th bit period.
    function automatic logic [15:0] frame_of(input byte unsigned b);
      logic [15:0] f;
      int ones;
      f    = '1;
      f[0] = 1'b0;
      ones = 0;
      for (int i = 0; i < D; i++) begin
        f[1+i] = b[i];
        ones += int'(b[i]);
      end
      if (P != 0) f[1+D] = ((ones % 2) == 1) ^ (P == 2);
      return f;
    endfunction

    initial begin
      tx_valid   = 1'b0;
      tx_data    = '0;
      drv_active = 1'b0;
      forever begin
        byte unsigned b;
        int w;
        @(posedge clk);
        #1;
        if (req_q[g].size() > 0) begin
          drv_active = 1'b1;
          b = req_q[g].pop_front();
          repeat ($urandom_range(gap_max, 0)) @(posedge clk);
          #1;
          tx_data  = D'(b);
          tx_valid = 1'b1;
          w = 0;
          @(negedge clk);
          while (!tx_ready && w < 3000) begin
            @(negedge clk);
            w++;
          end
          if (!tx_ready) begin
            check($sformatf("handshake_timeout_ch%0d", g), 0, 1);
            tx_valid = 1'b0;
          end else begin
            @(posedge clk);
            exp_q.push_back(b & 8'((1 << D) - 1));
            #1;
            tx_valid = 1'b0;
            tx_data  = D'($urandom);
            @(negedge clk);
            check($sformatf("ready_drop_ch%0d", g), int'(tx_ready), 0);
          end
          drv_active = 1'b0;
        end
      end
    end

    initial begin
      nbits = 0;
      got   = '1;
      ch_idle[g] = 1'b0;
      forever begin
        byte unsigned e;
        @(negedge clk);
        if (!reset_n) begin
          nbits = 0;
          got   = '1;
          exp_q.delete();
        end else if (baud_tick && busy) begin
          got[nbits] = txd;
          nbits++;
          if (nbits == FL) begin
            if (exp_q.size() == 0) begin
              check($sformatf("unexpected_frame_ch%0d", g), int'(got), 0);
            end else begin
              e = exp_q.pop_front();
              check($sformatf("frame_ch%0d_byte%0h", g, e), int'(got), int'(frame_of(e)));
            end
            nbits = 0;
            got   = '1;
          end
        end
        ch_idle[g] = (req_q[g].size() == 0) && !drv_active && (exp_q.size() == 0) &&
                     (nbits == 0) && tx_ready && !busy;
      end
    end
  end

  task automatic wait_idle(input string nm);
    bit all;
    all = 1'b0;
    for (int w = 0; w < 20000 && !all; w++) begin
      @(negedge clk);
      #1;
      all = 1'b1;
      for (int i = 0; i < NCH; i++) all &= ch_idle[i];
    end
    if (!all) check({"idle_timeout_", nm}, 0, 1);
  endtask

  task automatic measure_busy(input int ch, input int req, input string nm);
    int w;
    int n;
    w = 0;
    n = 0;
    while (!busy_v[ch] && w < 2000) begin
      @(negedge clk);
      w++;
    end
    while (busy_v[ch] && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check(nm, n, req);
  endtask

  task automatic push_all(input byte unsigned b);
    for (int i = 0; i < NCH; i++) req_q[i].push_back(b);
  endtask

  initial begin
    int k;
    int w;
    reset_n   = 1'b0;
    tick_mode = 1'b0;
    gap_max   = 3;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NCH; i++) begin
      check($sformatf("reset_txd_ch%0d", i), int'(txd_v[i]), 1);
      check($sformatf("reset_ready_ch%0d", i), int'(ready_v[i]), 1);
      check($sformatf("reset_busy_ch%0d", i), int'(busy_v[i]), 0);
    end
    #2;
    reset_n = 1'b1;

    req_q[0].push_back(8'h55);
    measure_busy(0, 40, "busy_len_55");
    wait_idle("55");

    push_all(8'h07);
    wait_idle("parity07");

    gap_max = 0;
    req_q[0].push_back(8'hA5);
    req_q[0].push_back(8'h3C);
    measure_busy(0, 80, "busy_len_b2b");
    wait_idle("b2b");

    push_all(8'h01);
    push_all(8'h02);
    push_all(8'h03);
    wait_idle("held_valid");
    gap_max = 3;

    for (int n = 0; n < 20; n++)
      for (int i = 0; i < NCH; i++) req_q[i].push_back(8'($urandom));
    wait_idle("random");

    tick_mode = 1'b1;
    for (int n = 0; n < 8; n++)
      for (int i = 0; i < NCH; i++) req_q[i].push_back(8'($urandom));
    wait_idle("double_tick");
    tick_mode = 1'b0;

    req_q[0].push_back(8'hFB);
    w = 0;
    while (!busy_v[0] && w < 2000) begin
      @(negedge clk);
      w++;
    end
    k = 0;
    w = 0;
    while (k < 3 && w < 200) begin
      @(posedge clk);
      w++;
      if (baud_tick) k++;
    end
    #2;
    check("bit2_before_reset", int'(txd_v[0]), 0);
    reset_n = 1'b0;
    #1;
    check("reset_txd_async", int'(txd_v[0]), 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("post_reset_ready", int'(ready_v[0]), 1);
    check("post_reset_busy", int'(busy_v[0]), 0);
    push_all(8'h5A);
    wait_idle("post_reset");

    for (int i = 0; i < NCH; i++)
      check($sformatf("drained_ch%0d", i), int'(ch_idle[i]), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
